ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_if.sv | 38 +++
 rtl/ex_mem_stage.sv | 173 +++++++++++++++++
 tb/tb_ex_mem_stage.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX bus: the instruction held in the ID/EX register plus the
// ready handshake back to the upstream pipeline register.
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      rs1_ad_p;
  logic [4:0]      rs2_ad_p;
  logic [4:0]      rd_ad_p;
  logic [XLEN-1:0] rs1_p;
  logic [XLEN-1:0] rs2_p;
  logic [XLEN-1:0] imm_p;
  logic [XLEN-1:0] pc_p;
  logic [3:0]      aluCont_p;
  logic            alumux1sel_p;
  logic            alumux2sel_p;
  logic            DMwriteEn_p;
  logic            DMread_p;
  logic            rdEn_p;
  logic            rs1_read_p;
  logic            rs2_read_p;
  logic [2:0]      DM_ctrl_p;

  modport master (
    output in_valid, rs1_ad_p, rs2_ad_p, rd_ad_p, rs1_p, rs2_p, imm_p, pc_p,
           aluCont_p, alumux1sel_p, alumux2sel_p, DMwriteEn_p, DMread_p,
           rdEn_p, rs1_read_p, rs2_read_p, DM_ctrl_p,
    input  in_ready
  );

  modport slave (
    input  in_valid, rs1_ad_p, rs2_ad_p, rd_ad_p, rs1_p, rs2_p, imm_p, pc_p,
           aluCont_p, alumux1sel_p, alumux2sel_p, DMwriteEn_p, DMread_p,
           rdEn_p, rs1_read_p, rs2_read_p, DM_ctrl_p,
    output in_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX stage with operand forwarding, load-use detection and the EX/MEM
// pipeline register. Optional iterative multiplier for ALU code 11 is
// enabled by defining EX_MUL_EN; without it code 11 yields 0.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_mem_stage_if.slave   idex,
  input  logic            wb_rdEn,
  input  logic [4:0]      wb_rd_ad,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            stall_in,
  input  logic            flush,
  output logic            valid_m,
  output logic [XLEN-1:0] alu_res_m,
  output logic [XLEN-1:0] store_data_m,
  output logic [4:0]      rd_ad_m,
  output logic            rdEn_m,
  output logic            DMwriteEn_m,
  output logic            DMread_m,
  output logic [2:0]      DM_ctrl_m,
  output logic            load_use_stall
);

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                             input logic signed [XLEN-1:0] a,
                                             input logic signed [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    alu_fn = a + b;
      4'd1:    alu_fn = a - b;
      4'd2:    alu_fn = a << sh;
      4'd3:    alu_fn = {{(XLEN-1){1'b0}}, (a < b)};
      4'd4:    alu_fn = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      4'd5:    alu_fn = a ^ b;
      4'd6:    alu_fn = $unsigned(a) >> sh;
      4'd7:    alu_fn = a >>> sh;
      4'd8:    alu_fn = a | b;
      4'd9:    alu_fn = a & b;
      4'd10:   alu_fn = b;
      default: alu_fn = '0;
    endcase
  endfunction

  // EX/MEM has priority over write-back; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      ad,
                                              input logic [XLEN-1:0] reg_val,
                                              input logic            ex_ok,
                                              input logic [4:0]      ex_ad,
                                              input logic [XLEN-1:0] ex_val,
                                              input logic            wb_ok,
                                              input logic [4:0]      wb_ad,
                                              input logic [XLEN-1:0] wb_val);
    if (ex_ok && ex_ad == ad && ad != 5'd0)      fwd_sel = ex_val;
    else if (wb_ok && wb_ad == ad && ad != 5'd0) fwd_sel = wb_val;
    else                                         fwd_sel = reg_val;
  endfunction

  logic                   ex_fwd_ok;
  logic signed [XLEN-1:0] rs1_fwd;
  logic signed [XLEN-1:0] rs2_fwd;
  logic signed [XLEN-1:0] op_a;
  logic signed [XLEN-1:0] op_b;
  logic [XLEN-1:0]        alu_out;
  logic [XLEN-1:0]        ex_result;
  logic                   busy;
  logic                   accept;

  // A load in EX/MEM has no data yet, so it is excluded from forwarding.
  assign ex_fwd_ok = valid_m & rdEn_m & ~DMread_m;
  assign rs1_fwd   = fwd_sel(idex.rs1_ad_p, idex.rs1_p, ex_fwd_ok, rd_ad_m, alu_res_m,
                             wb_rdEn, wb_rd_ad, wb_rd_data);
  assign rs2_fwd   = fwd_sel(idex.rs2_ad_p, idex.rs2_p, ex_fwd_ok, rd_ad_m, alu_res_m,
                             wb_rdEn, wb_rd_ad, wb_rd_data);
  assign op_a      = idex.alumux1sel_p ? idex.pc_p  : rs1_fwd;
  assign op_b      = idex.alumux2sel_p ? idex.imm_p : rs2_fwd;
  assign alu_out   = alu_fn(idex.aluCont_p, op_a, op_b);

  assign load_use_stall = idex.in_valid & valid_m & DMread_m & (rd_ad_m != 5'd0) &
                          ((idex.rs1_read_p & (idex.rs1_ad_p == rd_ad_m)) |
                           (idex.rs2_read_p & (idex.rs2_ad_p == rd_ad_m)));
  assign idex.in_ready  = ~stall_in & ~load_use_stall & ~busy;
  assign accept         = idex.in_valid & idex.in_ready & ~flush;

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  mul_state_e       state;
  mul_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic             is_mul;
  logic             mul_start;

  assign is_mul    = (idex.aluCont_p == 4'd11);
  assign mul_start = (state == MUL_IDLE) & idex.in_valid & is_mul & ~load_use_stall & ~flush;
  assign busy      = ((state == MUL_IDLE) & idex.in_valid & is_mul) | (state == MUL_RUN);
  assign ex_result = (state == MUL_DONE) ? acc : alu_out;

  // Multiplier FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  // Next state: RUN spans XLEN cycles; DONE waits until the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (mul_start) state_nxt = MUL_RUN;
      MUL_RUN: begin
        if (flush)                           state_nxt = MUL_IDLE;
        else if (cnt == CNT_W'(XLEN - 1))    state_nxt = MUL_DONE;
      end
      MUL_DONE: if (flush || !idex.in_valid || idex.in_ready) state_nxt = MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit per RUN cycle, low XLEN bits kept.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= '0;
    end else if (state == MUL_RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign busy      = 1'b0;
  assign ex_result = alu_out;
`endif

  // ---- EX / MEM pipeline boundary ----
  // EX/MEM register: load on accept, bubble when idle, hold under stall_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m      <= 1'b0;
      alu_res_m    <= '0;
      store_data_m <= '0;
      rd_ad_m      <= 5'd0;
      rdEn_m       <= 1'b0;
      DMwriteEn_m  <= 1'b0;
      DMread_m     <= 1'b0;
      DM_ctrl_m    <= 3'd0;
    end else if (flush) begin
      valid_m <= 1'b0;
    end else if (!stall_in) begin
      valid_m <= accept;
      if (accept) begin
        alu_res_m    <= ex_result;
        store_data_m <= rs2_fwd;
        rd_ad_m      <= idex.rd_ad_p;
        rdEn_m       <= idex.rdEn_p;
        DMwriteEn_m  <= idex.DMwriteEn_p;
        DMread_m     <= idex.DMread_p;
        DM_ctrl_m    <= idex.DM_ctrl_p;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: scoreboard of expected EX/MEM contents,
// one task per scenario. Multiply scenarios follow EX_MUL_EN.
module tb_ex_mem_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_rdEn = 1'b0;
  logic [4:0]      wb_rd_ad = 5'd0;
  logic [XLEN-1:0] wb_rd_data = '0;
  logic            stall_in = 1'b0;
  logic            flush = 1'b0;
  logic            valid_m;
  logic [XLEN-1:0] alu_res_m;
  logic [XLEN-1:0] store_data_m;
  logic [4:0]      rd_ad_m;
  logic            rdEn_m;
  logic            DMwriteEn_m;
  logic            DMread_m;
  logic [2:0]      DM_ctrl_m;
  logic            load_use_stall;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.XLEN(XLEN)) idex();

  ex_mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .idex(idex),
    .wb_rdEn(wb_rdEn), .wb_rd_ad(wb_rd_ad), .wb_rd_data(wb_rd_data),
    .stall_in(stall_in), .flush(flush),
    .valid_m(valid_m), .alu_res_m(alu_res_m), .store_data_m(store_data_m),
    .rd_ad_m(rd_ad_m), .rdEn_m(rdEn_m), .DMwriteEn_m(DMwriteEn_m),
    .DMread_m(DMread_m), .DM_ctrl_m(DM_ctrl_m), .load_use_stall(load_use_stall)
  );

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << s;
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> s;
      7:  return $unsigned($signed(a) >>> s);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic m1,
                       input logic m2, input logic ld, input logic rdw);
    idex.in_valid     = 1'b1;
    idex.aluCont_p    = op;
    idex.rs1_ad_p     = a1;
    idex.rs2_ad_p     = a2;
    idex.rd_ad_p      = ad;
    idex.rs1_p        = v1;
    idex.rs2_p        = v2;
    idex.imm_p        = imm;
    idex.pc_p         = pc;
    idex.alumux1sel_p = m1;
    idex.alumux2sel_p = m2;
    idex.DMread_p     = ld;
    idex.DMwriteEn_p  = 1'b0;
    idex.rdEn_p       = rdw;
    idex.rs1_read_p   = 1'b1;
    idex.rs2_read_p   = 1'b1;
    idex.DM_ctrl_p    = 3'b010;
  endtask

  task automatic push(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] rd);
    exp_t x;
    x.res = r; x.sd = sd; x.rd = rd;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    idex.in_valid = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idex.in_valid = 1'b0;
    #3;
    checks++;
    if (valid_m !== 1'b0 || alu_res_m !== 32'd0 || store_data_m !== 32'd0 || rd_ad_m !== 5'd0 ||
        rdEn_m !== 1'b0 || DMwriteEn_m !== 1'b0 || DMread_m !== 1'b0 || DM_ctrl_m !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b res=%h sd=%h rd=%0d en=%0b%0b%0b ctrl=%0d, required all zero",
               valid_m, alu_res_m, store_data_m, rd_ad_m, rdEn_m, DMwriteEn_m, DMread_m, DM_ctrl_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (idex.in_ready !== 1'b1 || load_use_stall !== 1'b0 || valid_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%0b lus=%0b valid=%0b, required 1 0 0",
               idex.in_ready, load_use_stall, valid_m);
    end
  endtask

  task automatic test_add();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd12, 32'd7, 5'd3);
    tick();
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd || store_data_m !== e.sd) begin
      failures++;
      $display("FAIL add: valid=%0b res=%h rd=%0d sd=%h, required 1 %h %0d %h",
               valid_m, alu_res_m, rd_ad_m, store_data_m, e.res, e.rd, e.sd);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] a, b, r2;
    for (int p = 0; p < 2; p++) begin
      for (int op = 0; op < 16; op++) begin
`ifdef EX_MUL_EN
        if (op == 11) continue;
`endif
        a  = (p == 1) ? 32'h8000_00F0 : 32'h0000_1234;
        b  = (p == 1) ? 32'h0000_0024 : 32'hFFFF_FFFE;
        r2 = (p == 1) ? 32'h0000_0055 : b;
        if (p == 1)
          drive(4'(op), 5'd1, 5'd2, 5'(op + 1), 32'hCAFE_0000, r2, b, a, 1'b1, 1'b1, 1'b0, 1'b0);
        else
          drive(4'(op), 5'd1, 5'd2, 5'(op + 1), a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(alu_ref(op, a, b), r2, 5'(op + 1));
        tick();
        e = sb.pop_front();
        checks++;
        if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd || store_data_m !== e.sd) begin
          failures++;
          $display("FAIL alu_op%0d_set%0d: valid=%0b res=%h rd=%0d sd=%h, required 1 %h %0d %h",
                   op, p, valid_m, alu_res_m, rd_ad_m, store_data_m, e.res, e.rd, e.sd);
        end
      end
    end
    idex.in_valid = 1'b0;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      failures++;
      $display("FAIL idle_bubble: valid=%0b, required 0", valid_m);
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd12, 32'd7, 5'd3);
    tick();
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res) begin
      failures++;
      $display("FAIL b2b_add: res=%h, required %h", alu_res_m, e.res);
    end
    drive(4'd1, 5'd3, 5'd1, 5'd4, 32'h0000_DEAD, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd7, 32'd5, 5'd4);
    tick();
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd || store_data_m !== e.sd) begin
      failures++;
      $display("FAIL b2b_sub_fwd: res=%h rd=%0d sd=%h, required %h %0d %h",
               alu_res_m, rd_ad_m, store_data_m, e.res, e.rd, e.sd);
    end
    // write to x0 then read x0: neither EX/MEM nor write-back may forward
    drive(4'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd59, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd99, 32'd59, 5'd0);
    tick();
    e = sb.pop_front();
    checks++;
    if (alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL x0_write: res=%h rd=%0d, required %h %0d", alu_res_m, rd_ad_m, e.res, e.rd);
    end
    wb_rdEn = 1'b1; wb_rd_ad = 5'd0; wb_rd_data = 32'h777;
    drive(4'd0, 5'd0, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd3, 32'd2, 5'd9);
    tick();
    wb_rdEn = 1'b0;
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res) begin
      failures++;
      $display("FAIL x0_no_fwd: res=%h, required %h", alu_res_m, e.res);
    end
  endtask

  task automatic test_wb_forward();
    drive(4'd0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd3, 32'd2, 5'd6);
    tick();
    e = sb.pop_front();
    checks++;
    if (alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL wbf_setup: res=%h rd=%0d, required %h %0d", alu_res_m, rd_ad_m, e.res, e.rd);
    end
    // both EX/MEM and write-back hold x6: EX/MEM value wins
    wb_rdEn = 1'b1; wb_rd_ad = 5'd6; wb_rd_data = 32'h50;
    drive(4'd0, 5'd6, 5'd7, 5'd10, 32'h1000, 32'h2000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h2003, 32'h2000, 5'd10);
    tick();
    e = sb.pop_front();
    checks++;
    if (alu_res_m !== e.res || store_data_m !== e.sd) begin
      failures++;
      $display("FAIL fwd_priority: res=%h sd=%h, required %h %h", alu_res_m, store_data_m, e.res, e.sd);
    end
    wb_rd_ad = 5'd7; wb_rd_data = 32'h40;
    drive(4'd0, 5'd6, 5'd7, 5'd11, 32'h1000, 32'h2000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h1040, 32'h40, 5'd11);
    tick();
    wb_rdEn = 1'b0;
    e = sb.pop_front();
    checks++;
    if (alu_res_m !== e.res || store_data_m !== e.sd) begin
      failures++;
      $display("FAIL wb_fwd_rs2: res=%h sd=%h, required %h %h", alu_res_m, store_data_m, e.res, e.sd);
    end
  endtask

  task automatic test_load_use();
    drive(4'd0, 5'd1, 5'd2, 5'd5, 32'h200, 32'd0, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    push(32'h210, 32'd0, 5'd5);
    tick();
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || DMread_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL load_issue: valid=%0b rd_en=%0b res=%h rd=%0d, required 1 1 %h %0d",
               valid_m, DMread_m, alu_res_m, rd_ad_m, e.res, e.rd);
    end
    drive(4'd0, 5'd5, 5'd1, 5'd7, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (load_use_stall !== 1'b1 || idex.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_use_detect: lus=%0b in_ready=%0b, required 1 0", load_use_stall, idex.in_ready);
    end
    // stall_in together with load-use: EX/MEM holds, no bubble yet
    stall_in = 1'b1;
    tick();
    checks++;
    if (valid_m !== 1'b1 || DMread_m !== 1'b1 || alu_res_m !== 32'h210) begin
      failures++;
      $display("FAIL lus_and_stall_hold: valid=%0b rd_en=%0b res=%h, required 1 1 00000210",
               valid_m, DMread_m, alu_res_m);
    end
    stall_in = 1'b0;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      failures++;
      $display("FAIL load_use_bubble: valid=%0b, required 0", valid_m);
    end
    wb_rdEn = 1'b1; wb_rd_ad = 5'd5; wb_rd_data = 32'h100;
    push(32'h105, 32'd5, 5'd7);
    #1;
    checks++;
    if (load_use_stall !== 1'b0 || idex.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_use_clear: lus=%0b in_ready=%0b, required 0 1", load_use_stall, idex.in_ready);
    end
    tick();
    wb_rdEn = 1'b0;
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL load_use_wb_fwd: valid=%0b res=%h rd=%0d, required 1 %h %0d",
               valid_m, alu_res_m, rd_ad_m, e.res, e.rd);
    end
  endtask

  task automatic test_stall_flush();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd12, 32'd7, 5'd3);
    tick();
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res) begin
      failures++;
      $display("FAIL stall_setup: valid=%0b res=%h, required 1 %h", valid_m, alu_res_m, e.res);
    end
    drive(4'd0, 5'd8, 5'd9, 5'd4, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (idex.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready_c%0d: in_ready=%0b, required 0", i, idex.in_ready);
      end
      tick();
      checks++;
      if (valid_m !== 1'b1 || alu_res_m !== 32'd12 || rd_ad_m !== 5'd3 || store_data_m !== 32'd7) begin
        failures++;
        $display("FAIL stall_hold_c%0d: valid=%0b res=%h rd=%0d sd=%h, required 1 0000000c 3 00000007",
                 i, valid_m, alu_res_m, rd_ad_m, store_data_m);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_stall: valid=%0b, required 0", valid_m);
    end
    flush = 1'b0;
    stall_in = 1'b0;
    idex.in_valid = 1'b0;
    tick();
    checks++;
    if (valid_m !== 1'b0) begin
      failures++;
      $display("FAIL post_flush: valid=%0b, required 0", valid_m);
    end
  endtask

  task automatic test_async_reset();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idex.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_m !== 1'b0 || alu_res_m !== 32'd0 || rdEn_m !== 1'b0 || rd_ad_m !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%0b res=%h rdEn=%0b rd=%0d, required all zero",
               valid_m, alu_res_m, rdEn_m, rd_ad_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int cnt;
    drive(4'd11, 5'd1, 5'd2, 5'd8, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'hFFFF_FFFD, 32'd3, 5'd8);
    #1;
    cnt = 0;
    while (idex.in_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 33) begin
      failures++;
      $display("FAIL mul_busy_cycles: saw %0d, required 33", cnt);
    end
    tick();
    idex.in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL mul_result: valid=%0b res=%h rd=%0d, required 1 %h %0d",
               valid_m, alu_res_m, rd_ad_m, e.res, e.rd);
    end
    // reset part way through: multiply restarts from IDLE afterwards
    drive(4'd11, 5'd1, 5'd2, 5'd9, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_m !== 1'b0) begin
      failures++;
      $display("FAIL mul_reset_valid: valid=%0b, required 0", valid_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(32'd42, 32'd6, 5'd9);
    #1;
    cnt = 0;
    while (idex.in_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 33) begin
      failures++;
      $display("FAIL mul_restart_cycles: saw %0d, required 33", cnt);
    end
    tick();
    idex.in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res) begin
      failures++;
      $display("FAIL mul_restart_result: valid=%0b res=%h, required 1 %h", valid_m, alu_res_m, e.res);
    end
  endtask
`else
  task automatic test_mul();
    drive(4'd11, 5'd1, 5'd2, 5'd8, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'd0, 32'd6, 5'd8);
    #1;
    checks++;
    if (idex.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_off_ready: in_ready=%0b, required 1", idex.in_ready);
    end
    tick();
    idex.in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (valid_m !== 1'b1 || alu_res_m !== e.res || rd_ad_m !== e.rd) begin
      failures++;
      $display("FAIL mul_off_result: valid=%0b res=%h rd=%0d, required 1 %h %0d",
               valid_m, alu_res_m, rd_ad_m, e.res, e.rd);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_back_to_back();
    test_wb_forward();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    test_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
